// File: rtl/systolic_sequencer_2x2.sv
// Sequencer for a 2x2 output-stationary systolic array: latches an operand pair,
// clears the array, feeds skewed row/column streams, drains, and holds C = A*B.
module systolic_sequencer_2x2 #(
  parameter int WIDTH        = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*WIDTH-1:0]   a_mat,
  input  logic [4*WIDTH-1:0]   b_mat,
  output logic                 arr_clear,
  output logic [WIDTH-1:0]     arr_a0,
  output logic [WIDTH-1:0]     arr_a1,
  output logic [WIDTH-1:0]     arr_b0,
  output logic [WIDTH-1:0]     arr_b1,
  input  logic [2*WIDTH-1:0]   arr_c00,
  input  logic [2*WIDTH-1:0]   arr_c01,
  input  logic [2*WIDTH-1:0]   arr_c10,
  input  logic [2*WIDTH-1:0]   arr_c11,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WIDTH-1:0]   result,
  output logic                 busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; the producer holds its data until then, and ready never depends on valid.

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int CW = $clog2(DRAIN_CYCLES + 3);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              capture;
  logic [4*WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0]  a0_nxt, a1_nxt, b0_nxt, b1_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt counts FEED steps (0..2) and then DRAIN cycles (0..DRAIN_CYCLES-1).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        state_nxt = S_FEED;
        cnt_nxt   = '0;
      end
      S_FEED: begin
        if (cnt == CW'(2)) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == CW'(DRAIN_CYCLES - 1)) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane values are chosen from the upcoming state/step so the flops present them
  // during exactly that cycle.
  always_comb begin
    a0_nxt = '0;
    a1_nxt = '0;
    b0_nxt = '0;
    b1_nxt = '0;
    if (state_nxt == S_FEED) begin
      if (cnt_nxt == CW'(0)) begin
        a0_nxt = a_q[0*WIDTH +: WIDTH];
        b0_nxt = b_q[0*WIDTH +: WIDTH];
      end else if (cnt_nxt == CW'(1)) begin
        a0_nxt = a_q[1*WIDTH +: WIDTH];
        a1_nxt = a_q[2*WIDTH +: WIDTH];
        b0_nxt = b_q[2*WIDTH +: WIDTH];
        b1_nxt = b_q[1*WIDTH +: WIDTH];
      end else begin
        a1_nxt = a_q[3*WIDTH +: WIDTH];
        b1_nxt = b_q[3*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_a0 <= '0;
      arr_a1 <= '0;
      arr_b0 <= '0;
      arr_b1 <= '0;
    end else begin
      arr_a0 <= a0_nxt;
      arr_a1 <= a1_nxt;
      arr_b0 <= b0_nxt;
      arr_b1 <= b1_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state == S_IDLE && in_valid) begin
      a_q <= a_mat;
      b_q <= b_mat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (capture) begin
      result <= {arr_c11, arr_c10, arr_c01, arr_c00};
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign arr_clear = (state == S_CLEAR);

endmodule
